// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the requester handshakes (instruction fetch and load/store) and
//   the single-port memory macro bus used by mem_port_arbiter.
//
//   Fetch side : IfReq, IfAddr        -> IfAck, IfRData
//   Data side  : DReq, DWrite, DSize,
//                DUnsigned, DAddr,
//                DWData               -> DAck, DRData, DErr
//   Memory side: MemRData             -> MemEn, MemWe, MemAddr,
//                                        MemByteEn, MemWData
//
//   master : arbiter view (drives acks, read data and the memory strobes)
//   slave  : environment view (requesters plus memory macro)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
    logic        IfReq;
    logic [31:0] IfAddr;
    logic        IfAck;
    logic [31:0] IfRData;

    logic        DReq;
    logic        DWrite;
    logic [1:0]  DSize;
    logic        DUnsigned;
    logic [31:0] DAddr;
    logic [31:0] DWData;
    logic        DAck;
    logic [31:0] DRData;
    logic        DErr;

    logic        MemEn;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemByteEn;
    logic [31:0] MemWData;
    logic [31:0] MemRData;

    modport master (
        input  IfReq, IfAddr,
        input  DReq, DWrite, DSize, DUnsigned, DAddr, DWData,
        input  MemRData,
        output IfAck, IfRData,
        output DAck, DRData, DErr,
        output MemEn, MemWe, MemAddr, MemByteEn, MemWData
    );

    modport slave (
        output IfReq, IfAddr,
        output DReq, DWrite, DSize, DUnsigned, DAddr, DWData,
        output MemRData,
        input  IfAck, IfRData,
        input  DAck, DRData, DErr,
        input  MemEn, MemWe, MemAddr, MemByteEn, MemWData
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between instruction fetch
//   (IF) and the load/store stage (D). Each access runs
//   IDLE (arbitrate) -> ISSUE (MemEn) -> [WAIT] -> RESP (Ack).
//   Generates byte enables / lane-placed store data for byte, half and word
//   stores and sign/zero-extends load data.
//
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high; drops any in-flight access
//   bus   : mem_port_arbiter_if.master (requester handshakes + memory bus)
//
//   Parameters
//     MEM_LATENCY  : cycles from MemEn to valid MemRData (1..7)
//     STARVE_LIMIT : D wins this many consecutive contested arbitrations
//                    before IF is forced through (1..15)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [2:0]  wait_q, wait_d;
    logic [3:0]  starve_q, starve_d;
    logic        err_q, err_d;
    logic        sel_d_q, sel_d_d;      // current access belongs to D
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        d_req_eff, if_wins, d_wins, d_bad;
    logic [3:0]  be;
    logic [31:0] wplace;
    logic [3:0][7:0] rd_lanes;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    // D is still asserting its request during the cycle its DErr is shown;
    // masking it there keeps the same bad request from being re-granted.
    assign d_req_eff = bus.DReq & ~err_q;
    assign if_wins   = bus.IfReq & (~d_req_eff | (starve_q >= STARVE_LIM));
    assign d_wins    = d_req_eff & ~if_wins;
    assign d_bad     = (bus.DSize == 2'b11) ||
                       (bus.DSize == 2'b01 && bus.DAddr[0]) ||
                       (bus.DSize == 2'b10 && bus.DAddr[1:0] != 2'b00);

    // Byte enables and store lane placement from the latched operands.
    // Fetches latch size=word, so they always read all four lanes.
    always_comb begin
        be     = 4'b1111;
        wplace = wdata_q;
        case (size_q)
            2'b00: begin
                be     = 4'b0001 << addr_q[1:0];
                wplace = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be     = 4'b0011 << {addr_q[1], 1'b0};
                wplace = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction and extension.
    assign rd_lanes = bus.MemRData;
    assign rd_byte  = rd_lanes[addr_q[1:0]];
    assign rd_half  = addr_q[1] ? bus.MemRData[31:16] : bus.MemRData[15:0];

    always_comb begin
        load_ext = bus.MemRData;
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        starve_d   = starve_q;
        err_d      = 1'b0;
        sel_d_d    = sel_d_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        if (!bus.IfReq) starve_d = 4'd0;

        case (state_q)
            IDLE: begin
                if (if_wins) begin
                    starve_d = 4'd0;
                    sel_d_d  = 1'b0;
                    we_d     = 1'b0;
                    size_d   = 2'b10;
                    uns_d    = 1'b0;
                    addr_d   = bus.IfAddr;
                    wdata_d  = 32'd0;
                    state_d  = ISSUE;
                end else if (d_wins) begin
                    if (bus.IfReq && starve_q != 4'hF) starve_d = starve_q + 4'd1;
                    // A bad request still consumes its grant; it just never
                    // reaches the memory.
                    if (d_bad) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d_d = 1'b1;
                        we_d    = bus.DWrite;
                        size_d  = bus.DSize;
                        uns_d   = bus.DUnsigned;
                        addr_d  = bus.DAddr;
                        wdata_d = bus.DWData;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    wait_d  = WAIT_INIT;
                    state_d = WAIT;
                end
            end
            // Reads stay here MEM_LATENCY cycles; the last one is the cycle
            // MemRData is valid, so the capture lands on its closing edge and
            // Ack + data appear together in RESP.
            WAIT: begin
                if (wait_q == 3'd0) begin
                    if (sel_d_q) d_rdata_d  = load_ext;
                    else         if_rdata_d = load_ext;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            wait_q     <= 3'd0;
            starve_q   <= 4'd0;
            err_q      <= 1'b0;
            sel_d_q    <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            starve_q   <= starve_d;
            err_q      <= err_d;
            sel_d_q    <= sel_d_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Memory bus is only non-zero in ISSUE so idle cycles present a clean 0.
    assign bus.MemEn     = (state_q == ISSUE);
    assign bus.MemWe     = (state_q == ISSUE) & we_q;
    assign bus.MemAddr   = (state_q == ISSUE) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus.MemByteEn = (state_q == ISSUE) ? be : 4'd0;
    assign bus.MemWData  = ((state_q == ISSUE) && we_q) ? wplace : 32'd0;

    assign bus.IfAck   = (state_q == RESP) & ~sel_d_q;
    assign bus.DAck    = (state_q == RESP) &  sel_d_q;
    assign bus.DErr    = err_q;
    assign bus.IfRData = if_rdata_q;
    assign bus.DRData  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Instance A runs MEM_LATENCY=1,
//   instance B runs MEM_LATENCY=3; both use STARVE_LIMIT=4. A small
//   read-only memory model returns data exactly MEM_LATENCY cycles after
//   MemEn and X in every other cycle.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    typedef struct {
        int          lat;
        int          en_c;
        int          nen;
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] mwd;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic        mwe;
    } res_t;

    logic Clk;
    logic rst_a, rst_b;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if ifa ();
    mem_port_arbiter_if ifb ();

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
        .Clk(Clk), .Reset(rst_a), .bus(ifa)
    );
    mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut_b (
        .Clk(Clk), .Reset(rst_b), .bus(ifb)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ---------------- memory model ----------------
    logic [31:0] mem [0:255];
    logic        a_v;
    logic [31:0] a_d;
    logic [2:0]  b_v;
    logic [31:0] b_d0, b_d1, b_d2;

    always @(posedge Clk) begin
        a_v  <= ifa.MemEn & ~ifa.MemWe;
        a_d  <= mem[ifa.MemAddr[9:2]];
        b_v  <= {b_v[1:0], ifb.MemEn & ~ifb.MemWe};
        b_d0 <= mem[ifb.MemAddr[9:2]];
        b_d1 <= b_d0;
        b_d2 <= b_d1;
    end
    assign ifa.MemRData = a_v    ? a_d  : 32'hxxxxxxxx;
    assign ifb.MemRData = b_v[2] ? b_d2 : 32'hxxxxxxxx;

    // ---------------- monitors ----------------
    int a_en_cnt = 0, b_en_cnt = 0, b_ack_cnt = 0, multi_a = 0, multi_b = 0;
    always @(negedge Clk) begin
        if (ifa.MemEn) a_en_cnt <= a_en_cnt + 1;
        if (ifb.MemEn) b_en_cnt <= b_en_cnt + 1;
        if (ifb.IfAck || ifb.DAck || ifb.DErr) b_ack_cnt <= b_ack_cnt + 1;
        if (int'(ifa.IfAck) + int'(ifa.DAck) + int'(ifa.DErr) > 1) multi_a <= multi_a + 1;
        if (int'(ifb.IfAck) + int'(ifb.DAck) + int'(ifb.DErr) > 1) multi_b <= multi_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One access on instance A. Request is raised at the start of cycle 0;
    // lat is the cycle in which Ack/Err is seen (-1 if it never came).
    task automatic a_acc(input logic is_f, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wd, output res_t r);
        r.lat = -1; r.en_c = -1; r.nen = 0; r.ack = 0; r.err = 0;
        r.rdata = 0; r.mwd = 0; r.maddr = 0; r.be = 0; r.mwe = 0;
        if (is_f) begin
            ifa.IfReq = 1'b1; ifa.IfAddr = addr;
        end else begin
            ifa.DReq = 1'b1; ifa.DWrite = we; ifa.DSize = sz;
            ifa.DUnsigned = uns; ifa.DAddr = addr; ifa.DWData = wd;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (ifa.MemEn) begin
                if (r.en_c < 0) r.en_c = c;
                r.nen++;
                r.be = ifa.MemByteEn; r.mwd = ifa.MemWData;
                r.mwe = ifa.MemWe; r.maddr = ifa.MemAddr;
            end
            if (is_f ? ifa.IfAck : (ifa.DAck || ifa.DErr)) begin
                r.ack   = is_f ? ifa.IfAck : ifa.DAck;
                r.err   = is_f ? 1'b0 : ifa.DErr;
                r.rdata = is_f ? ifa.IfRData : ifa.DRData;
                r.lat   = c;
                break;
            end
            step();
        end
        step();
        ifa.IfReq = 1'b0; ifa.DReq = 1'b0; ifa.DWrite = 1'b0;
        step();
        step();
    endtask

    res_t r;
    int   en0, dack_c, iack_c, lat, en_c, nseq, ack0;
    logic [31:0] rd;
    logic [31:0] seq [6];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h40] = 32'h8C220004;   // 0x100
        mem[8'h80] = 32'h80FF7F01;   // 0x200
        mem[8'h10] = 32'h11223344;   // 0x040

        ifa.IfReq = 0; ifa.IfAddr = 0; ifa.DReq = 0; ifa.DWrite = 0;
        ifa.DSize = 0; ifa.DUnsigned = 0; ifa.DAddr = 0; ifa.DWData = 0;
        ifb.IfReq = 0; ifb.IfAddr = 0; ifb.DReq = 0; ifb.DWrite = 0;
        ifb.DSize = 0; ifb.DUnsigned = 0; ifb.DAddr = 0; ifb.DWData = 0;
        rst_a = 1; rst_b = 1;
        step(); step();
        @(negedge Clk);
        chk("rst_ctl", {27'd0, ifa.MemEn, ifa.MemWe, ifa.IfAck, ifa.DAck, ifa.DErr}, 32'd0);
        chk("rst_be_addr", {ifa.MemByteEn, ifa.MemAddr[27:0]}, 32'd0);
        chk("rst_rdata", ifa.IfRData | ifa.DRData | ifa.MemWData, 32'd0);
        chk("rst_starve", {28'd0, dut_a.starve_q}, 32'd0);
        step();
        rst_a = 0; rst_b = 0;
        step();

        // ---- fetch only, latency 1 ----
        a_acc(1, 0, 2'b10, 0, 32'h100, 0, r);
        chk("fetch_lat", 32'(r.lat), 32'd3);
        chk("fetch_en_cycle", 32'(r.en_c), 32'd1);
        chk("fetch_be", {28'd0, r.be}, 32'hF);
        chk("fetch_addr", r.maddr, 32'h100);
        chk("fetch_data", r.rdata, 32'h8C220004);

        // ---- loads from 0x80FF7F01 ----
        a_acc(0, 0, 2'b00, 0, 32'h203, 0, r); chk("lb_203", r.rdata, 32'hFFFFFF80);
        chk("load_lat", 32'(r.lat), 32'd3);
        a_acc(0, 0, 2'b00, 1, 32'h203, 0, r); chk("lbu_203", r.rdata, 32'h00000080);
        a_acc(0, 0, 2'b01, 0, 32'h202, 0, r); chk("lh_202", r.rdata, 32'hFFFF80FF);
        a_acc(0, 0, 2'b01, 1, 32'h202, 0, r); chk("lhu_202", r.rdata, 32'h000080FF);
        a_acc(0, 0, 2'b00, 0, 32'h201, 0, r); chk("lb_201", r.rdata, 32'h0000007F);
        a_acc(0, 0, 2'b01, 0, 32'h200, 0, r); chk("lh_200", r.rdata, 32'h00007F01);
        a_acc(0, 0, 2'b10, 1, 32'h200, 0, r); chk("lw_uns", r.rdata, 32'h80FF7F01);

        // ---- stores ----
        a_acc(0, 1, 2'b00, 0, 32'h301, 32'h000000AB, r);
        chk("sb_be", {28'd0, r.be}, 32'b0010);
        chk("sb_wdata", r.mwd, 32'hABABABAB);
        chk("sb_we_ack", {30'd0, r.mwe, r.ack}, 32'b11);
        chk("sb_lat", 32'(r.lat), 32'd2);
        chk("sb_addr", r.maddr, 32'h300);
        a_acc(0, 1, 2'b01, 0, 32'h302, 32'h00001234, r);
        chk("sh_be", {28'd0, r.be}, 32'b1100);
        chk("sh_wdata", r.mwd, 32'h12341234);
        a_acc(0, 1, 2'b10, 0, 32'h300, 32'hDEADBEEF, r);
        chk("sw_be_wdata", r.mwd ^ {28'd0, r.be}, 32'hDEADBEE0);

        // ---- errors: no memory access, DErr next cycle ----
        en0 = a_en_cnt;
        a_acc(0, 0, 2'b01, 0, 32'h301, 0, r);
        chk("sh301_err", {30'd0, r.err, r.ack}, 32'b10);
        chk("sh301_err_lat", 32'(r.lat), 32'd1);
        a_acc(0, 0, 2'b10, 0, 32'h302, 0, r);
        chk("lw302_err", {30'd0, r.err, r.ack}, 32'b10);
        a_acc(0, 1, 2'b11, 0, 32'h300, 0, r);
        chk("size11_err", {30'd0, r.err, r.ack}, 32'b10);
        chk("err_no_memen", 32'(a_en_cnt - en0), 32'd0);
        a_acc(0, 0, 2'b10, 0, 32'h200, 0, r);
        chk("after_err_lw", r.rdata, 32'h80FF7F01);
        chk("after_err_ack", {30'd0, r.err, r.ack}, 32'b01);

        // ---- simultaneous IF and D ----
        ifa.IfReq = 1; ifa.IfAddr = 32'h100;
        ifa.DReq = 1; ifa.DWrite = 0; ifa.DSize = 2'b10; ifa.DUnsigned = 0; ifa.DAddr = 32'h200;
        dack_c = -1; iack_c = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge Clk);
            if (c == 1) begin
                chk("sim_first_addr", ifa.MemAddr, 32'h200);
                chk("sim_starve_1", {28'd0, dut_a.starve_q}, 32'd1);
            end
            if (c == 4) chk("sim_starve_held", {28'd0, dut_a.starve_q}, 32'd1);
            if (c == 5) chk("sim_starve_clr", {28'd0, dut_a.starve_q}, 32'd0);
            if (ifa.DAck && dack_c < 0) begin
                dack_c = c;
                chk("sim_drdata", ifa.DRData, 32'h80FF7F01);
            end
            if (ifa.IfAck && iack_c < 0) begin
                iack_c = c;
                chk("sim_ifrdata", ifa.IfRData, 32'h8C220004);
            end
            step();
            if (dack_c >= 0) ifa.DReq = 0;
            if (iack_c >= 0) ifa.IfReq = 0;
        end
        ifa.DReq = 0; ifa.IfReq = 0;
        chk("sim_dack_cycle", 32'(dack_c), 32'd3);
        chk("sim_iack_cycle", 32'(iack_c), 32'd7);
        step(); step();

        // ---- starvation: both held, IF forced on 5th arbitration ----
        ifa.IfReq = 1; ifa.IfAddr = 32'h100;
        ifa.DReq = 1; ifa.DWrite = 0; ifa.DSize = 2'b10; ifa.DAddr = 32'h200;
        nseq = 0;
        for (int i = 0; i < 6; i++) seq[i] = 32'hFFFFFFFF;
        for (int c = 0; c < 40 && nseq < 6; c++) begin
            @(negedge Clk);
            if (ifa.MemEn) begin
                seq[nseq] = ifa.MemAddr;
                nseq++;
            end
            step();
        end
        ifa.IfReq = 0; ifa.DReq = 0;
        for (int i = 0; i < 6; i++)
            chk($sformatf("starve_grant%0d", i), seq[i], (i == 4) ? 32'h100 : 32'h200);
        for (int i = 0; i < 6; i++) step();

        // ---- instance B: latency 3 fetch ----
        ifb.IfReq = 1; ifb.IfAddr = 32'h40;
        lat = -1; en_c = -1; rd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (ifb.MemEn && en_c < 0) en_c = c;
            if (ifb.IfAck) begin
                lat = c; rd = ifb.IfRData;
                break;
            end
            step();
        end
        step();
        ifb.IfReq = 0;
        step(); step();
        chk("b_fetch_lat", 32'(lat), 32'd5);
        chk("b_fetch_en_cycle", 32'(en_c), 32'd1);
        chk("b_fetch_data", rd, 32'h11223344);

        // ---- instance B: reset during WAIT ----
        ifb.IfReq = 1; ifb.IfAddr = 32'h100;
        @(negedge Clk);                       // cycle 0: arbitrate
        step();
        @(negedge Clk);                       // cycle 1: issue
        chk("b_rst_issue", {31'd0, ifb.MemEn}, 32'd1);
        step();
        rst_b = 1; ifb.IfReq = 0;             // cycle 2: inside WAIT
        @(negedge Clk);
        chk("b_wait_quiet", {30'd0, ifb.MemEn, ifb.IfAck}, 32'd0);
        step();
        rst_b = 0;
        @(negedge Clk);                       // cycle 3: after reset
        chk("b_rst_ctl", {27'd0, ifb.MemEn, ifb.MemWe, ifb.IfAck, ifb.DAck, ifb.DErr}, 32'd0);
        chk("b_rst_rdata", ifb.IfRData | ifb.DRData, 32'd0);
        chk("b_rst_bus", ifb.MemAddr | ifb.MemWData | {28'd0, ifb.MemByteEn}, 32'd0);
        ack0 = b_ack_cnt; en0 = b_en_cnt;
        for (int i = 0; i < 10; i++) step();
        chk("b_rst_no_ack", 32'(b_ack_cnt - ack0), 32'd0);
        chk("b_rst_no_memen", 32'(b_en_cnt - en0), 32'd0);

        chk("one_ack_a", 32'(multi_a), 32'd0);
        chk("one_ack_b", 32'(multi_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
